// File: rtl/interrupt_vector_sequencer.sv
// Interrupt/reset entry sequencer for the 6502 core: owns the bus for the
// 7-step RESET/NMI/IRQ/BRK entry and loads the fetched vector into the PC.
module interrupt_vector_sequencer (
   input  logic        sys_clock,
   input  logic        reset,
   input  logic        clk_ph2_enable,
   input  logic        nmi_n,
   input  logic        irq_n,
   input  logic        i_flag,
   input  logic        brk_req,
   input  logic        insn_boundary,
   input  logic [7:0]  PCL_in,
   input  logic [7:0]  PCH_in,
   input  logic [7:0]  P_in,
   input  logic [7:0]  SP_in,
   input  logic [7:0]  data_in,
   output logic [15:0] addr_out,
   output logic [7:0]  data_out,
   output logic        rw_out,
   output logic        busy,
   output logic [7:0]  ADL_out,
   output logic [7:0]  ADH_out,
   output logic        ADL_load_en,
   output logic        ADH_load_en,
   output logic [7:0]  sp_out,
   output logic        sp_load,
   output logic        set_I,
   output logic        done,
   output logic [3:0]  o_dbg_state
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_T1   = 4'd1,
      S_T2   = 4'd2,
      S_T3   = 4'd3,
      S_T4   = 4'd4,
      S_T5   = 4'd5,
      S_T6   = 4'd6,
      S_T7   = 4'd7
   } state_t;

   typedef enum logic [1:0] {
      K_RST = 2'd0,
      K_NMI = 2'd1,
      K_BRK = 2'd2,
      K_IRQ = 2'd3
   } kind_t;

   state_t      r_state, w_state;
   kind_t       r_kind, w_kind, w_sel;
   logic        r_rst_pend, w_rst_pend;
   logic        r_nmi_pend, w_nmi_pend;
   logic        r_nmi_prev, w_nmi_prev;
   logic [15:0] r_pc, w_pc;
   logic [7:0]  r_sp, w_sp;
   logic [7:0]  r_p, w_p;
   logic [15:0] r_vec, w_vec;
   logic [7:0]  r_vec_lo, w_vec_lo;
   logic [15:0] r_addr, w_addr;
   logic [7:0]  r_data, w_data;
   logic        r_rw, w_rw;
   logic        r_busy, w_busy;
   logic [7:0]  r_adl, w_adl;
   logic [7:0]  r_adh, w_adh;
   logic        r_load, w_load;
   logic [7:0]  r_sp_out, w_sp_out;
   logic        w_go;
   logic        w_nmi_fall;
   logic [7:0]  w_sp_m1, w_sp_m2, w_sp_m3;

   assign w_nmi_fall = clk_ph2_enable & r_nmi_prev & ~nmi_n;
   assign w_sp_m1    = r_sp - 8'd1;
   assign w_sp_m2    = r_sp - 8'd2;
   assign w_sp_m3    = r_sp - 8'd3;

   always_comb begin
      w_state    = r_state;
      w_kind     = r_kind;
      w_sel      = K_IRQ;
      w_go       = 1'b0;
      w_rst_pend = r_rst_pend;
      w_nmi_pend = r_nmi_pend;
      w_nmi_prev = r_nmi_prev;
      w_pc       = r_pc;
      w_sp       = r_sp;
      w_p        = r_p;
      w_vec      = r_vec;
      w_vec_lo   = r_vec_lo;
      w_addr     = r_addr;
      w_data     = r_data;
      w_rw       = r_rw;
      w_busy     = r_busy;
      w_adl      = r_adl;
      w_adh      = r_adh;
      w_load     = 1'b0;
      w_sp_out   = r_sp_out;

      if (clk_ph2_enable) begin
         w_nmi_prev = nmi_n;
         case (r_state)
            S_IDLE: begin
               // Reset entry ignores the boundary; everything else waits for it.
               if (r_rst_pend) begin
                  w_go  = 1'b1;
                  w_sel = K_RST;
               end else if (insn_boundary) begin
                  if (r_nmi_pend) begin
                     w_go  = 1'b1;
                     w_sel = K_NMI;
                  end else if (brk_req) begin
                     w_go  = 1'b1;
                     w_sel = K_BRK;
                  end else if (!irq_n && !i_flag) begin
                     w_go  = 1'b1;
                     w_sel = K_IRQ;
                  end
               end
               if (w_go) begin
                  w_state = S_T1;
                  w_kind  = w_sel;
                  w_pc    = {PCH_in, PCL_in};
                  w_sp    = (w_sel == K_RST) ? 8'h00 : SP_in;
                  w_p     = {P_in[7:6], 1'b1, (w_sel == K_BRK), P_in[3:0]};
                  case (w_sel)
                     K_NMI:   w_vec = 16'hFFFA;
                     K_RST:   w_vec = 16'hFFFC;
                     default: w_vec = 16'hFFFE;
                  endcase
                  w_busy = 1'b1;
                  w_addr = {PCH_in, PCL_in};
                  w_rw   = 1'b1;
                  if (w_sel == K_RST) w_rst_pend = 1'b0;
                  if (w_sel == K_NMI) w_nmi_pend = 1'b0;
               end
            end
            S_T1: begin
               w_state = S_T2;
               w_addr  = r_pc;
               w_rw    = 1'b1;
            end
            S_T2: begin
               w_state = S_T3;
               w_addr  = {8'h01, r_sp};
               w_data  = r_pc[15:8];
               w_rw    = (r_kind == K_RST);
            end
            S_T3: begin
               w_state = S_T4;
               w_addr  = {8'h01, w_sp_m1};
               w_data  = r_pc[7:0];
               w_rw    = (r_kind == K_RST);
            end
            S_T4: begin
               w_state = S_T5;
               w_addr  = {8'h01, w_sp_m2};
               w_data  = r_p;
               w_rw    = (r_kind == K_RST);
            end
            S_T5: begin
               w_state = S_T6;
               // A pending NMI hijacks IRQ/BRK here; the pushed P is already out.
               if ((r_kind == K_BRK || r_kind == K_IRQ) && r_nmi_pend) begin
                  w_vec      = 16'hFFFA;
                  w_nmi_pend = 1'b0;
               end
               w_addr = w_vec;
               w_rw   = 1'b1;
            end
            S_T6: begin
               w_state  = S_T7;
               w_vec_lo = data_in;
               w_addr   = r_vec + 16'd1;
               w_rw     = 1'b1;
            end
            S_T7: begin
               w_state  = S_IDLE;
               w_adl    = r_vec_lo;
               w_adh    = data_in;
               w_load   = 1'b1;
               w_sp_out = w_sp_m3;
               w_busy   = 1'b0;
            end
            default: w_state = S_IDLE;
         endcase
         if (w_nmi_fall) w_nmi_pend = 1'b1;
      end
   end

   always_ff @(posedge sys_clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_kind     <= K_RST;
         r_rst_pend <= 1'b1;
         r_nmi_pend <= 1'b0;
         r_nmi_prev <= 1'b1;
         r_pc       <= 16'h0000;
         r_sp       <= 8'h00;
         r_p        <= 8'h00;
         r_vec      <= 16'h0000;
         r_vec_lo   <= 8'h00;
         r_addr     <= 16'h0000;
         r_data     <= 8'h00;
         r_rw       <= 1'b1;
         r_busy     <= 1'b0;
         r_adl      <= 8'h00;
         r_adh      <= 8'h00;
         r_load     <= 1'b0;
         r_sp_out   <= 8'h00;
      end else begin
         r_state    <= w_state;
         r_kind     <= w_kind;
         r_rst_pend <= w_rst_pend;
         r_nmi_pend <= w_nmi_pend;
         r_nmi_prev <= w_nmi_prev;
         r_pc       <= w_pc;
         r_sp       <= w_sp;
         r_p        <= w_p;
         r_vec      <= w_vec;
         r_vec_lo   <= w_vec_lo;
         r_addr     <= w_addr;
         r_data     <= w_data;
         r_rw       <= w_rw;
         r_busy     <= w_busy;
         r_adl      <= w_adl;
         r_adh      <= w_adh;
         r_load     <= w_load;
         r_sp_out   <= w_sp_out;
      end
   end

   // Load strobes are one-way, single-cycle pulses with no back-pressure:
   // the PC, SP and P registers must capture on the cycle they are high.
   assign addr_out    = r_addr;
   assign data_out    = r_data;
   assign rw_out      = r_rw;
   assign busy        = r_busy;
   assign ADL_out     = r_adl;
   assign ADH_out     = r_adh;
   assign ADL_load_en = r_load;
   assign ADH_load_en = r_load;
   assign sp_load     = r_load;
   assign set_I       = r_load;
   assign done        = r_load;
   assign sp_out      = r_sp_out;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_interrupt_vector_sequencer.sv
// Bench for interrupt_vector_sequencer: directed entry scenarios followed by
// randomized IRQ/BRK/NMI traffic against a transaction-level model.
module tb_interrupt_vector_sequencer;

   localparam int K_NONE = 0;
   localparam int K_RST  = 1;
   localparam int K_NMI  = 2;
   localparam int K_BRK  = 3;
   localparam int K_IRQ  = 4;
   localparam logic [63:0] RESV = {9'h0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 5'h00, 8'h00};

   logic        sys_clock = 1'b0;
   logic        reset = 1'b1;
   logic        clk_ph2_enable = 1'b0;
   logic        nmi_n = 1'b1;
   logic        irq_n = 1'b1;
   logic        i_flag = 1'b0;
   logic        brk_req = 1'b0;
   logic        insn_boundary = 1'b0;
   logic [7:0]  PCL_in = 8'h00;
   logic [7:0]  PCH_in = 8'h00;
   logic [7:0]  P_in = 8'h00;
   logic [7:0]  SP_in = 8'h00;
   logic [7:0]  data_in;
   logic [15:0] addr_out;
   logic [7:0]  data_out;
   logic        rw_out;
   logic        busy;
   logic [7:0]  ADL_out;
   logic [7:0]  ADH_out;
   logic        ADL_load_en;
   logic        ADH_load_en;
   logic [7:0]  sp_out;
   logic        sp_load;
   logic        set_I;
   logic        done;
   logic [3:0]  dbg_state;

   interrupt_vector_sequencer dut (
      .sys_clock      (sys_clock),
      .reset          (reset),
      .clk_ph2_enable (clk_ph2_enable),
      .nmi_n          (nmi_n),
      .irq_n          (irq_n),
      .i_flag         (i_flag),
      .brk_req        (brk_req),
      .insn_boundary  (insn_boundary),
      .PCL_in         (PCL_in),
      .PCH_in         (PCH_in),
      .P_in           (P_in),
      .SP_in          (SP_in),
      .data_in        (data_in),
      .addr_out       (addr_out),
      .data_out       (data_out),
      .rw_out         (rw_out),
      .busy           (busy),
      .ADL_out        (ADL_out),
      .ADH_out        (ADH_out),
      .ADL_load_en    (ADL_load_en),
      .ADH_load_en    (ADH_load_en),
      .sp_out         (sp_out),
      .sp_load        (sp_load),
      .set_I          (set_I),
      .done           (done),
      .o_dbg_state    (dbg_state)
   );

   always #5 sys_clock = ~sys_clock;

   // Vector table memory at 0xFFF8..0xFFFF; everything else reads as NOP.
   logic [7:0] vec_mem [8];
   assign data_in = (addr_out[15:3] == 13'h1FFF) ? vec_mem[addr_out[2:0]] : 8'hEA;

   logic [4:0]  w_strobes;
   logic [63:0] w_resvals;
   assign w_strobes = {ADL_load_en, ADH_load_en, set_I, sp_load, done};
   assign w_resvals = {9'h0, addr_out, data_out, rw_out, busy, ADL_out, ADH_out, w_strobes, sp_out};

   int n_checks = 0;
   int n_pass   = 0;
   int en_period = 1;
   bit rst_pend = 1'b0;
   bit nmi_pend = 1'b0;
   logic [24:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cycle(input bit en);
      @(negedge sys_clock);
      clk_ph2_enable = en;
      @(posedge sys_clock);
      #1;
   endtask

   task automatic en_edge();
      for (int i = 1; i < en_period; i++) begin
         cycle(1'b0);
         check("strobe_idle", w_strobes, 5'h00);
      end
      cycle(1'b1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      nmi_n = 1'b1;
      cycle(1'b0);
      cycle(1'b1);
      check("reset_vals", w_resvals, RESV);
      reset = 1'b0;
      rst_pend = 1'b1;
      nmi_pend = 1'b0;
   endtask

   task automatic make_nmi_pending();
      insn_boundary = 1'b0;
      nmi_n = 1'b1;
      en_edge();
      nmi_n = 1'b0;
      en_edge();
      nmi_pend = 1'b1;
      check("nmi_latch_idle", busy, 1'b0);
   endtask

   // Stimulate one boundary and, if the model says it is accepted, check the
   // whole entry sequence. nmi_e (2..7) drops nmi_n just before that edge.
   task automatic run_seq(input logic [15:0] pc, input logic [7:0] sp, input logic [7:0] p,
                          input bit brk, input bit irq, input bit iflag,
                          input int nmi_e, input int abort_at, input bit release_nmi);
      int          kind;
      bit          hijack;
      bit          wr;
      logic [15:0] vec;
      logic [7:0]  sp0, pp, lo, hi;
      logic [2:0]  idx, idx_hi;
      logic [24:0] e;
      kind = rst_pend ? K_RST : nmi_pend ? K_NMI : brk ? K_BRK :
             (irq && !iflag) ? K_IRQ : K_NONE;
      {PCH_in, PCL_in} = pc;
      SP_in = sp;
      P_in = p;
      brk_req = brk;
      irq_n = ~irq;
      i_flag = iflag;
      insn_boundary = 1'b1;
      en_edge();
      insn_boundary = 1'b0;
      brk_req = 1'b0;
      irq_n = 1'b1;
      {PCH_in, PCL_in} = 16'($urandom);
      SP_in = 8'($urandom);
      P_in = 8'($urandom);
      if (kind == K_NONE) begin
         check("no_accept", busy, 1'b0);
         return;
      end
      hijack = (kind == K_BRK || kind == K_IRQ) && nmi_e >= 2 && nmi_e <= 5;
      vec = (kind == K_NMI || hijack) ? 16'hFFFA : (kind == K_RST) ? 16'hFFFC : 16'hFFFE;
      sp0 = (kind == K_RST) ? 8'h00 : sp;
      pp = {p[7:6], 1'b1, (kind == K_BRK), p[3:0]};
      wr = (kind == K_RST);
      idx = vec[2:0];
      idx_hi = idx + 3'd1;
      lo = vec_mem[idx];
      hi = vec_mem[idx_hi];
      exp_q = {};
      exp_q.push_back({1'b1, 8'h00, pc});
      exp_q.push_back({1'b1, 8'h00, pc});
      exp_q.push_back({wr, pc[15:8], 8'h01, sp0});
      exp_q.push_back({wr, pc[7:0], 8'h01, 8'(sp0 - 8'd1)});
      exp_q.push_back({wr, pp, 8'h01, 8'(sp0 - 8'd2)});
      exp_q.push_back({1'b1, 8'h00, vec});
      exp_q.push_back({1'b1, 8'h00, 16'(vec + 16'd1)});
      for (int k = 1; k <= 7; k++) begin
         if (k > 1) begin
            if (nmi_e == k) nmi_n = 1'b0;
            en_edge();
         end
         e = exp_q.pop_front();
         check($sformatf("busy_t%0d", k), busy, 1'b1);
         check($sformatf("bus_t%0d", k), {rw_out, addr_out}, {e[24], e[15:0]});
         if (!e[24]) check($sformatf("wdata_t%0d", k), data_out, e[23:16]);
         if (abort_at == k) begin
            reset = 1'b1;
            cycle(1'b0);
            check("abort_reset", w_resvals, RESV);
            reset = 1'b0;
            nmi_n = 1'b1;
            rst_pend = 1'b1;
            nmi_pend = 1'b0;
            return;
         end
      end
      en_edge();
      check("strobes", w_strobes, 5'h1F);
      check("pc_load", {ADH_out, ADL_out}, {hi, lo});
      check("sp_out", sp_out, 8'(sp0 - 8'd3));
      check("busy_end", busy, 1'b0);
      cycle(1'b0);
      check("strobe_width", w_strobes, 5'h00);
      if (kind == K_RST) rst_pend = 1'b0;
      if (kind == K_NMI) nmi_pend = (nmi_e >= 2);
      else if (kind != K_RST) nmi_pend = (nmi_e >= 6);
      if (release_nmi) begin
         nmi_n = 1'b1;
         en_edge();
         check("idle_after", busy, 1'b0);
      end
   endtask

   initial begin
      vec_mem[0] = 8'h11; vec_mem[1] = 8'h22;
      vec_mem[2] = 8'h00; vec_mem[3] = 8'h90;
      vec_mem[4] = 8'h34; vec_mem[5] = 8'h12;
      vec_mem[6] = 8'h78; vec_mem[7] = 8'hA5;

      // Power-on RESET: suppressed pushes from sp=0x00, vector 0x1234.
      do_reset();
      run_seq(16'h4321, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

      // IRQ masked, then taken.
      run_seq(16'h8000, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1);
      run_seq(16'h8000, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1);

      // BRK pushes P with B set.
      run_seq(16'hC002, 8'hF0, 8'h01, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);

      // NMI beats BRK and IRQ; held-low NMI does not retrigger.
      make_nmi_pending();
      run_seq(16'h2000, 8'hE0, 8'h80, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      insn_boundary = 1'b1;
      for (int i = 0; i < 3; i++) begin
         en_edge();
         check("nmi_held_low", busy, 1'b0);
      end
      insn_boundary = 1'b0;
      make_nmi_pending();
      run_seq(16'h2100, 8'h03, 8'hC3, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

      // NMI edge during T4 hijacks an IRQ; nothing pending afterwards.
      run_seq(16'h9ABC, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b0, 5, 0, 1'b1);
      insn_boundary = 1'b1;
      en_edge();
      check("no_nmi_left", busy, 1'b0);
      insn_boundary = 1'b0;

      // NMI edge during T6 stays pending and is taken at the next boundary.
      run_seq(16'h5555, 8'h80, 8'h04, 1'b1, 1'b0, 1'b0, 7, 0, 1'b1);
      run_seq(16'h6666, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

      // Sparse enable, then reset in T5 followed by a full RESET entry.
      en_period = 3;
      run_seq(16'h8000, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
      run_seq(16'hC002, 8'h10, 8'h01, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
      run_seq(16'h1234, 8'h40, 8'h00, 1'b0, 1'b1, 1'b0, 0, 5, 1'b1);
      run_seq(16'h0000, 8'h99, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
      en_period = 1;

      for (int n = 0; n < 16; n++) begin
         en_period = $urandom_range(1, 3);
         for (int j = 0; j < 8; j++) vec_mem[j] = 8'($urandom);
         run_seq(16'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 7)) : 0, 0, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", n_checks, n_pass);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/interrupt_vector_sequencer.md
# interrupt_vector_sequencer

Drives the 6502 core's program counter load path and bus during RESET, NMI, IRQ and BRK entry. On an accepted request it performs the 7-step entry sequence:
- two dummy reads;
- three stack pushes;
- two vector reads.

It then loads the fetched vector into the program counter through its ADL/ADH load inputs. It is the writer side of the PC's address-bus load interface and sits beside the instruction decoder in the CPU core.

## Interface
Parameters:
- none

Ports:
- sys_clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- clk_ph2_enable  in  1  step enable; FSM, NMI detector and data_in sampling act only on sys_clock edges with this high
- nmi_n  in  1  NMI line, falling-edge sensitive
- irq_n  in  1  IRQ line, level sensitive, active low
- i_flag  in  1  interrupt-disable flag from P
- brk_req  in  1  decoder has a BRK opcode at this boundary
- insn_boundary  in  1  core is at an opcode-fetch boundary; requests accepted only here
- PCL_in, PCH_in  in  8 each  current PC (BRK: already PC+2)
- P_in  in  8  status register
- SP_in  in  8  stack pointer
- data_in  in  8  read data bus
- addr_out  out  16  bus address
- data_out  out  8  write data
- rw_out  out  1  1=read, 0=write
- busy  out  1  sequencer owns the bus
- ADL_out, ADH_out  out  8 each  vector to the PC
- ADL_load_en, ADH_load_en  out  1  PC load strobes
- sp_out  out  8  final stack pointer
- sp_load  out  1  SP load strobe
- set_I  out  1  set I flag strobe
- done  out  1  sequence complete strobe

## Operation
Priority at acceptance: reset-pending > NMI-pending > brk_req > IRQ (irq_n=0 and i_flag=0).

Acceptance rules:
- RESET starts on the first enabled edge after reset deasserts, with insn_boundary ignored.
- All others require state IDLE, insn_boundary=1 and an enabled edge.

States: IDLE → T1 → T2 → T3 → T4 → T5 → T6 → T7 → IDLE. Each state advances on one enabled edge.

Bus activity per state (registered on the entering edge):
- T1 and T2: addr = {PCH_in, PCL_in} latched at acceptance; rw = 1.
- T3: addr = 0x0100|sp, data = PCH.
- T4: addr = 0x0100|(sp-1), data = PCL.
- T5: addr = 0x0100|(sp-2), data = P'.
- T6: addr = vector; rw = 1.
- T7: addr = vector+1; rw = 1.

Stack pointer source:
- Internal sp is latched from SP_in at acceptance.
- RESET forces sp to 0x00.

Push rules:
- T3–T5 use rw=0, except RESET, which keeps rw=1 (suppressed writes) but still decrements.
- P' = P_in with bit5=1 and bit4=1 for BRK; bit4=0 for IRQ/NMI.

Vectors:
- NMI 0xFFFA.
- RESET 0xFFFC.
- IRQ/BRK 0xFFFE.

NMI detection:
- Latched when nmi_n is 0 on an enabled edge and was 1 on the previous enabled edge.
- Pending is cleared when an NMI sequence is accepted or a hijack is taken.
- IRQ is not latched; it must be held low until acceptance.

NMI hijack: if NMI is pending at the edge entering T6 of an IRQ/BRK sequence:
- the vector becomes 0xFFFA;
- pending is cleared;
- the pushed P' is unchanged.

Completion:
- The edge leaving T6 samples data_in as the vector low byte.
- The edge leaving T7 samples data_in as the vector high byte and asserts, for exactly one sys_clock cycle, ADL_load_en=ADH_load_en=1, set_I=1, sp_load=1 and done=1.
- It also drives ADL_out=low, ADH_out=high and sp_out=sp-3 (mod 256).
- The FSM returns to IDLE with busy=0.

Stack address arithmetic: sp wraps mod 256; the page stays 0x01.

## Timing
- Reset values: state IDLE, reset-pending=1, NMI pending=0. Outputs: addr_out=0x0000, data_out=0x00, rw_out=1, busy=0, ADL_out=ADH_out=0x00, all strobes 0, sp_out=0x00.
- busy rises on the acceptance edge and falls on the completion edge. Acceptance to load strobe is 8 enabled edges.
- With clk_ph2_enable low, every register and output holds, and strobes stay 0 after their single cycle.
- Reset asserted mid-sequence aborts immediately: outputs go to reset values with no PC load, and RESET restarts after deassertion.
- An NMI edge during T6 or T7 stays pending and is taken at the next boundary.
- Simultaneous NMI-pending and brk_req: NMI is taken, and the BRK is lost (the decoder re-fetches).

## Test plan
- Reset, SP_in=0x55, memory 0xFFFC=0x34, 0xFFFD=0x12: rw stays 1 throughout, stack addresses are 0x0100/0x01FF/0x01FE, and the PC load is 0x1234 with sp_out=0xFD.
- IRQ low with i_flag=1: no acceptance. Then i_flag=0, PC=0x8000, SP=0xFF, P=0x00: writes 0x80@0x01FF, 0x00@0x01FE, 0x20@0x01FD; vector read 0xFFFE; sp_out=0xFC; set_I pulses.
- BRK with PC=0xC002 and P=0x01: P' pushed is 0x31 and the vector is 0xFFFE.
- NMI edge and IRQ both active at the boundary: NMI taken with vector 0xFFFA. With nmi_n held low, no second NMI occurs until nmi_n returns high and falls again.
- IRQ sequence with an NMI edge during T4: P' has bit4=0, the vector reads at 0xFFFA/0xFFFB, and no NMI remains pending afterwards.
- clk_ph2_enable pulsed every 3rd cycle: identical bus and strobe sequence, with each strobe exactly 1 sys_clock wide. Reset asserted at T5: no PC load, then a full RESET sequence follows.
